streebog_core_subtractor: RTL and testbench



---
 rtl/streebog_core_subtractor.sv | 125 ++++++++++++
 tb/tb_streebog_core_subtractor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/streebog_core_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : streebog_core_subtractor
// Brief    : Iterative modular subtractor, diff = (x - y) mod 2^WIDTH.
//            One LIMB-bit limb per clock with a registered borrow, so no
//            wide carry chain is built. The ena/rdy handshake matches the
//            companion 512-bit modular adder, so this block can undo its
//            accumulator updates.
// Revision : 1.0 - initial release
// ============================================================================
module streebog_core_subtractor #(
    parameter int WIDTH = 512,
    parameter int LIMB  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic             rdy,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             wrap
);

    localparam int c_nlimb = WIDTH / LIMB;
    localparam int c_cw    = (c_nlimb > 1) ? $clog2(c_nlimb) : 1;
    localparam logic [c_cw-1:0] c_last_limb = c_cw'(c_nlimb - 1);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state_q,  w_state_d;
    logic [WIDTH-1:0]  r_xs_q,     w_xs_d;
    logic [WIDTH-1:0]  r_ys_q,     w_ys_d;
    logic [WIDTH-1:0]  r_acc_q,    w_acc_d;
    logic [c_cw-1:0]   r_cnt_q,    w_cnt_d;
    logic              r_borrow_q, w_borrow_d;
    logic [WIDTH-1:0]  r_diff_q,   w_diff_d;
    logic              r_wrap_q,   w_wrap_d;

    // Limb difference: bit LIMB of the result is the borrow out of this limb.
    logic [LIMB:0]     w_sub;
    // Current limb result placed at the MSB end, ready to be ORed into acc.
    logic [WIDTH-1:0]  w_limb_ext;

    assign w_sub = {1'b0, r_xs_q[LIMB-1:0]}
                 - {1'b0, r_ys_q[LIMB-1:0]}
                 - {{LIMB{1'b0}}, r_borrow_q};

    assign rdy  = (r_state_q == S_IDLE);
    assign diff = r_diff_q;
    assign wrap = r_wrap_q;

    // Next-state logic: capture on accept, then one limb per BUSY cycle.
    always_comb begin
        w_state_d  = r_state_q;
        w_xs_d     = r_xs_q;
        w_ys_d     = r_ys_q;
        w_acc_d    = r_acc_q;
        w_cnt_d    = r_cnt_q;
        w_borrow_d = r_borrow_q;
        w_diff_d   = r_diff_q;
        w_wrap_d   = r_wrap_q;
        w_limb_ext = '0;
        w_limb_ext[WIDTH-1 -: LIMB] = w_sub[LIMB-1:0];

        case (r_state_q)
            S_IDLE: begin
                if (ena) begin
                    w_xs_d     = x;
                    w_ys_d     = y;
                    w_cnt_d    = '0;
                    w_borrow_d = 1'b0;
                    w_state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                w_xs_d     = r_xs_q >> LIMB;
                w_ys_d     = r_ys_q >> LIMB;
                w_acc_d    = (r_acc_q >> LIMB) | w_limb_ext;
                w_borrow_d = w_sub[LIMB];
                w_cnt_d    = r_cnt_q + c_cnt_one;
                // Publish only the complete result; the MSB-limb borrow is
                // dropped from diff and reported on wrap instead.
                if (r_cnt_q == c_last_limb) begin
                    w_diff_d  = (r_acc_q >> LIMB) | w_limb_ext;
                    w_wrap_d  = w_sub[LIMB];
                    w_cnt_d   = '0;
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_xs_q     <= '0;
            r_ys_q     <= '0;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_borrow_q <= 1'b0;
            r_diff_q   <= '0;
            r_wrap_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_xs_q     <= w_xs_d;
            r_ys_q     <= w_ys_d;
            r_acc_q    <= w_acc_d;
            r_cnt_q    <= w_cnt_d;
            r_borrow_q <= w_borrow_d;
            r_diff_q   <= w_diff_d;
            r_wrap_q   <= w_wrap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_streebog_core_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_streebog_core_subtractor
// Brief    : Scoreboard bench for streebog_core_subtractor. Stimulus pushes
//            expected {diff, wrap} from an arithmetic reference model; an
//            independent monitor pops and compares on each completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_streebog_core_subtractor;

    localparam int WIDTH  = 512;
    localparam int LIMB   = 32;
    localparam int NLIMB  = WIDTH / LIMB;
    localparam int N_RAND = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             rdy;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] diff;
    logic             wrap;

    logic [WIDTH-1:0] exp_d_q[$];
    logic             exp_w_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    streebog_core_subtractor #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .rdy  (rdy),
        .x    (x),
        .y    (y),
        .diff (diff),
        .wrap (wrap)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand512();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < NLIMB; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: plain (WIDTH+1)-bit subtraction; the top bit is the borrow.
    function automatic void ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] d, output logic w);
        logic [WIDTH:0] t;
        t = {1'b0, a} - {1'b0, b};
        d = t[WIDTH-1:0];
        w = t[WIDTH];
    endfunction

    // Wait (after an edge) until the DUT is idle, bounded.
    task automatic wait_idle();
        int n = 0;
        while (rdy !== 1'b1) begin
            @(posedge clk); #2;
            n++;
            if (n > 100) begin
                $display("FAIL wait_idle: rdy=%b after %0d cycles, required 1", rdy, n);
                $fatal(1, "timeout");
            end
        end
    endtask

    // Issue one operation with its expected result; inputs scrambled after accept.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] ed, input logic ew);
        wait_idle();
        x = a; y = b; ena = 1'b1;
        exp_d_q.push_back(ed);
        exp_w_q.push_back(ew);
        @(posedge clk); #2;
        ena = 1'b0;
        x = rand512(); y = rand512();
    endtask

    task automatic start_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] ed;
        logic             ew;
        ref_sub(a, b, ed, ew);
        start_op(a, b, ed, ew);
    endtask

    // Monitor: sample on the falling edge, check reset, hold and completions.
    initial begin : monitor
        logic             prev_rdy = 1'b1;
        logic             last_rst = 1'b0;
        logic             hold_ok  = 1'b1;
        int               busy     = 0;
        logic [WIDTH-1:0] held_d   = '0;
        logic             held_w   = 1'b0;
        logic [WIDTH-1:0] ed;
        logic             ew;
        forever begin
            @(negedge clk);
            if (last_rst) begin
                check("reset_rdy",  WIDTH'(rdy),  WIDTH'(1));
                check("reset_diff", diff,         '0);
                check("reset_wrap", WIDTH'(wrap), '0);
                if (!prev_rdy && exp_d_q.size() > 0) begin
                    void'(exp_d_q.pop_front());
                    void'(exp_w_q.pop_front());
                end
                busy = 0; hold_ok = 1'b1;
            end else if (rdy === 1'b0) begin
                if (prev_rdy) begin busy = 0; hold_ok = 1'b1; end
                busy++;
                if (diff !== held_d || wrap !== held_w) hold_ok = 1'b0;
            end else if (!prev_rdy) begin
                check("busy_cycles", WIDTH'(busy), WIDTH'(NLIMB));
                check("hold_during_busy", WIDTH'(hold_ok), WIDTH'(1));
                if (exp_d_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_result: got diff %h with empty scoreboard", diff);
                end else begin
                    ed = exp_d_q.pop_front();
                    ew = exp_w_q.pop_front();
                    check("diff", diff, ed);
                    check("wrap", WIDTH'(wrap), WIDTH'(ew));
                end
            end
            if (rdy === 1'b1) begin held_d = diff; held_w = wrap; end
            prev_rdy = (rdy === 1'b1);
            last_rst = rst;
        end
    end

    initial begin : stimulus
        logic [WIDTH-1:0] a, b, z, ones, p;
        logic [WIDTH:0]   s;
        int               n;
        rst = 1'b1; ena = 1'b0; x = '0; y = '0;
        ones = '1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Simple case.
        start_op(WIDTH'(5), WIDTH'(3), WIDTH'(2), 1'b0);
        // Full wrap and equal operands.
        start_op('0, WIDTH'(1), ones, 1'b1);
        a = rand512();
        start_op(a, a, '0, 1'b0);
        // Borrow ripple across 15 limbs, and MSB-only subtrahend.
        p = '0; p[480] = 1'b1;
        start_op(p, WIDTH'(1), {32'h0, ones[479:0]}, 1'b0);
        p = '0; p[511] = 1'b1;
        z = p; z[0] = 1'b1;
        start_op(WIDTH'(1), p, z, 1'b1);

        // Handshake: ena held high while busy with changing inputs is ignored;
        // the next capture happens on the first idle edge.
        wait_idle();
        x = WIDTH'(10); y = WIDTH'(4); ena = 1'b1;
        exp_d_q.push_back(WIDTH'(6)); exp_w_q.push_back(1'b0);
        @(posedge clk); #2;
        n = 0;
        while (rdy !== 1'b1) begin
            x = rand512(); y = rand512();
            @(posedge clk); #2;
            n++;
            if (n > 100) begin
                $display("FAIL handshake_wait: rdy=%b after %0d cycles, required 1", rdy, n);
                $fatal(1, "timeout");
            end
        end
        check("accept_period", WIDTH'(n), WIDTH'(NLIMB));
        a = rand512(); b = rand512();
        x = a; y = b;
        ref_sub(a, b, z, s[0]);
        exp_d_q.push_back(z); exp_w_q.push_back(s[0]);
        @(posedge clk); #2;
        ena = 1'b0; x = rand512(); y = rand512();

        // Reset in the middle of an operation.
        start_ref(rand512(), rand512());
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        start_op(WIDTH'(7), WIDTH'(9), ones - WIDTH'(1), 1'b1);

        // Random regression, including adder round-trips.
        for (int i = 0; i < N_RAND; i++) begin
            case ($urandom_range(0, 3))
                0: start_ref(rand512(), rand512());
                1: begin
                    b = rand512(); z = rand512();
                    s = {1'b0, b} + {1'b0, z};
                    start_op(s[WIDTH-1:0], b, z, s[WIDTH]);
                end
                2: begin
                    a = rand512();
                    start_ref(a, a ^ WIDTH'($urandom_range(0, 3)));
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? ones : '0;
                    b = ($urandom_range(0, 1) == 1) ? ones : WIDTH'($urandom);
                    start_ref(a, b);
                end
            endcase
        end

        // Drain the scoreboard.
        n = 0;
        while (exp_d_q.size() != 0 && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        check("scoreboard_drained", WIDTH'(exp_d_q.size()), '0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
